mac_acc_pipe: RTL and testbench

- Pipelined, parametrised multiply-accumulate engine for dot products.
- Accepts one unsigned a/b operand pair per cycle and accumulates a*b over a vector delimited by in_last.
- Emits the vector sum with a one-cycle out_valid strobe, plus a term count and an overflow indication.
- Sequential successor to the combinational 8-bit MAC micro-benchmark; it sits in the micro_benchmark set as a clocked DSP/carry-chain stress design.

---
 rtl/mac_acc_pipe.sv | 139 +++++++++++++
 tb/tb_mac_acc_pipe.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mac_acc_pipe.sv
// Two-stage pipelined unsigned multiply-accumulate for dot products, vectors framed by in_last.
// Optional build macro MAC_ACC_SATURATE_EN clamps the accumulator to all-ones after an overflow.
module mac_acc_pipe #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ACC_WIDTH  = 24,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic                  in_last,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [ACC_WIDTH-1:0]  out,
  output logic                  out_valid,
  output logic [CNT_WIDTH-1:0]  out_count,
  output logic                  out_ovf,
  output logic                  busy
);

  localparam int unsigned PROD_WIDTH = 2 * DATA_WIDTH;
  localparam int unsigned SUM_WIDTH  = ACC_WIDTH + 1;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_ACCUM = 1'b1
  } state_t;

  state_t                state;
  state_t                state_next;

  logic [PROD_WIDTH-1:0] prod;
  logic [ACC_WIDTH-1:0]  p1;
  logic                  v1;
  logic                  l1;

  logic [ACC_WIDTH-1:0]  acc;
  logic [CNT_WIDTH-1:0]  cnt;
  logic                  ovf_sticky;

  logic [SUM_WIDTH-1:0]  sum;
  logic                  carry;
  logic                  ovf_next;
  logic [ACC_WIDTH-1:0]  acc_new;
  logic [CNT_WIDTH-1:0]  cnt_next;

  // Full-precision product of the two operands.
  always_comb begin
    prod = PROD_WIDTH'(a) * PROD_WIDTH'(b);
  end

  // Stage 1: register the product and its framing.
  always_ff @(posedge clk) begin
    if (rst) begin
      p1 <= '0;
      v1 <= 1'b0;
      l1 <= 1'b0;
    end else begin
      v1 <= in_valid;
      if (in_valid) begin
        p1 <= ACC_WIDTH'(prod);
        l1 <= in_last;
      end
    end
  end

  // Stage 2 arithmetic: one extra sum bit exposes the carry out of the accumulator.
  always_comb begin
    sum      = SUM_WIDTH'(acc) + SUM_WIDTH'(p1);
    carry    = sum[ACC_WIDTH];
    ovf_next = ovf_sticky | carry;
    cnt_next = (cnt == {CNT_WIDTH{1'b1}}) ? cnt : cnt + CNT_WIDTH'(1);
`ifdef MAC_ACC_SATURATE_EN
    acc_new  = ovf_next ? {ACC_WIDTH{1'b1}} : sum[ACC_WIDTH-1:0];
`else
    acc_new  = sum[ACC_WIDTH-1:0];
`endif
  end

  // Stage 2: accumulate, or publish the result and restart on the last term.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc        <= '0;
      cnt        <= '0;
      ovf_sticky <= 1'b0;
      out        <= '0;
      out_count  <= '0;
      out_ovf    <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (v1) begin
        if (l1) begin
          out        <= acc_new;
          out_count  <= cnt_next;
          out_ovf    <= ovf_next;
          out_valid  <= 1'b1;
          acc        <= '0;
          cnt        <= '0;
          ovf_sticky <= 1'b0;
        end else begin
          acc        <= acc_new;
          cnt        <= cnt_next;
          ovf_sticky <= ovf_next;
        end
      end
    end
  end

  // Vector state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ACCUM while a term will sit in stage 1 or a partial sum survives this edge.
  always_comb begin
    state_next = state;
    if (in_valid) begin
      state_next = S_ACCUM;
    end else if (v1) begin
      state_next = l1 ? S_IDLE : S_ACCUM;
    end else begin
      state_next = (cnt != '0) ? S_ACCUM : S_IDLE;
    end
  end

  // Output decode of the vector state.
  always_comb begin
    busy = 1'b0;
    if (state == S_ACCUM) begin
      busy = 1'b1;
    end
  end

endmodule

// File: tb/tb_mac_acc_pipe.sv
// Self-checking bench for mac_acc_pipe: directed steps plus random vectors vs a per-vector sum model.
module tb_mac_acc_pipe;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 16;
  localparam int unsigned CW = 8;
  localparam longint ACC_MOD = longint'(1) << AW;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_last;
  logic [DW-1:0] a;
  logic [DW-1:0] b;
  logic [AW-1:0] out;
  logic          out_valid;
  logic [CW-1:0] out_count;
  logic          out_ovf;
  logic          busy;

  always #5 clk = ~clk;

  mac_acc_pipe #(
    .DATA_WIDTH(DW),
    .ACC_WIDTH (AW),
    .CNT_WIDTH (CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_last  (in_last),
    .a        (a),
    .b        (b),
    .out      (out),
    .out_valid(out_valid),
    .out_count(out_count),
    .out_ovf  (out_ovf),
    .busy     (busy)
  );

  int     n_assert = 0;
  int     n_fail   = 0;

  // Open vector (terms sampled so far) and result due on the following edge.
  longint acc_m = 0;
  int     cnt_m = 0;
  bit     ovf_m = 1'b0;
  bit     pend = 1'b0;
  longint pend_out = 0;
  int     pend_cnt = 0;
  bit     pend_ovf = 1'b0;
  longint held_out = 0;
  int     held_cnt = 0;
  bit     held_ovf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, update the model at the edge, check at the falling edge.
  task automatic step(input bit r, input bit v, input bit l, input int av, input int bv);
    bit     exp_valid;
    bit     exp_busy;
    longint term;
    rst      = r;
    in_valid = v;
    in_last  = l;
    a        = DW'(av);
    b        = DW'(bv);
    @(posedge clk);
    if (r) begin
      acc_m = 0; cnt_m = 0; ovf_m = 1'b0; pend = 1'b0;
      held_out = 0; held_cnt = 0; held_ovf = 1'b0;
      exp_valid = 1'b0;
      exp_busy  = 1'b0;
    end else begin
      exp_valid = pend;
      if (pend) begin
        held_out = pend_out; held_cnt = pend_cnt; held_ovf = pend_ovf;
      end
      pend     = 1'b0;
      exp_busy = v || (cnt_m != 0);
      if (v) begin
        term  = longint'(a) * longint'(b);
        acc_m = acc_m + term;
        if (acc_m >= ACC_MOD) ovf_m = 1'b1;
`ifdef MAC_ACC_SATURATE_EN
        if (ovf_m) acc_m = ACC_MOD - 1;
`else
        acc_m = acc_m % ACC_MOD;
`endif
        cnt_m = (cnt_m + 1 > CNT_MAX) ? CNT_MAX : cnt_m + 1;
        if (l) begin
          pend = 1'b1; pend_out = acc_m; pend_cnt = cnt_m; pend_ovf = ovf_m;
          acc_m = 0; cnt_m = 0; ovf_m = 1'b0;
        end
      end
    end
    @(negedge clk);
    chk("out_valid", 32'(out_valid), 32'(exp_valid));
    chk("busy",      32'(busy),      32'(exp_busy));
    chk("out",       32'(out),       32'(held_out));
    chk("out_count", 32'(out_count), 32'(held_cnt));
    chk("out_ovf",   32'(out_ovf),   32'(held_ovf));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic term(input bit l, input int av, input int bv);
    step(1'b0, 1'b1, l, av, bv);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int len;
    // Reset then quiet idle.
    step(1'b1, 1'b0, 1'b0, 0, 0);
    step(1'b1, 1'b0, 1'b0, 0, 0);
    idle(10);

    // Basic three-term vector: 12 + 30 + 56.
    term(1'b0, 3, 4);
    term(1'b0, 5, 6);
    term(1'b1, 7, 8);
    idle(3);

    // Back-to-back vectors without bubbles.
    term(1'b1, 2, 2);
    term(1'b0, 10, 10);
    term(1'b1, 1, 1);
    idle(3);

    // Accumulator overflow at 16 bits.
    term(1'b0, 255, 255);
    term(1'b0, 255, 255);
    term(1'b0, 255, 255);
    term(1'b1, 255, 255);
    idle(3);

    // Idle gaps inside a vector.
    term(1'b0, 1, 1);
    idle(3);
    term(1'b1, 2, 3);
    idle(3);

    // Reset mid-vector discards the partial sum and the in-flight term.
    term(1'b0, 9, 9);
    term(1'b0, 9, 9);
    step(1'b1, 1'b0, 1'b0, 0, 0);
    term(1'b1, 1, 1);
    idle(3);

    // Term counter saturation.
    for (int i = 0; i < 300; i++) term(i == 299, 1, 1);
    idle(3);

    // Random vectors with random gaps and operand magnitudes.
    for (int v = 0; v < 40; v++) begin
      len = int'($urandom_range(1, 8));
      for (int t = 0; t < len; t++) begin
        if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
        if ($urandom_range(0, 1) == 0)
          term(t == len - 1, int'($urandom_range(200, 255)), int'($urandom_range(200, 255)));
        else
          term(t == len - 1, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
      end
      if ($urandom_range(0, 2) == 0) idle(1);
    end
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
